// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode fields in, staged controls and hazard/forward/PC-select out
//   master: drives OpcodeD, FunctD, RsD, RtD, RdD, ZeroM; observes everything else
//   slave : the control unit side (inputs/outputs mirrored)
interface pipe_hazard_ctrl_if;
   logic [5:0] OpcodeD, FunctD;
   logic [4:0] RsD, RtD, RdD;
   logic       ZeroM;
   logic       RegDstE, ALUSrcE, MemWriteM, MemToRegW, RegWriteW;
   logic [2:0] ALUControlE;
   logic [1:0] PCSel, ForwardAE, ForwardBE;
   logic       StallF, StallD, FlushD, FlushE;
   modport master (
      output OpcodeD, FunctD, RsD, RtD, RdD, ZeroM,
      input  RegDstE, ALUSrcE, ALUControlE, MemWriteM, MemToRegW, RegWriteW,
      input  PCSel, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
   );
   modport slave (
      input  OpcodeD, FunctD, RsD, RtD, RdD, ZeroM,
      output RegDstE, ALUSrcE, ALUControlE, MemWriteM, MemToRegW, RegWriteW,
      output PCSel, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline control decode, E/M/W control registers and hazard unit
//   clk   : rising-edge clock
//   reset : asynchronous active-low clear of all stage registers
//   bus   : slave side; Decode fields and ZeroM in, staged controls, PCSel,
//           StallF/StallD, FlushD/FlushE, ForwardAE/ForwardBE out
module pipe_hazard_ctrl (
   input  logic clk,
   input  logic reset,
   pipe_hazard_ctrl_if.slave bus
);
   typedef struct packed {
      logic       rw, m2r, mw, br;
      logic [2:0] alu;
      logic       as, rdst;
      logic [4:0] rs, rt, rd;
   } e_t;
   typedef struct packed {
      logic       rw, m2r, mw, br;
      logic [4:0] wr;
   } m_t;
   typedef struct packed {
      logic       rw, m2r;
      logic [4:0] wr;
   } w_t;
   e_t         d_c, e_q;
   m_t         m_q;
   w_t         w_q;
   logic       j_d, lw_stall, pcsrc_m, jump_go;
   logic [4:0] wr_e;
   always_comb begin
      d_c = '0;
      d_c.alu = 3'b010;
      d_c.rs = bus.RsD;
      d_c.rt = bus.RtD;
      d_c.rd = bus.RdD;
      j_d = 1'b0;
      case (bus.OpcodeD)
         6'b000000: begin
            {d_c.rw, d_c.rdst} = 2'b11;
            case (bus.FunctD)
               6'b100000: d_c.alu = 3'b010;
               6'b100010: d_c.alu = 3'b110;
               6'b100100: d_c.alu = 3'b000;
               6'b100101: d_c.alu = 3'b001;
               6'b101010: d_c.alu = 3'b111;
               default:   {d_c.rw, d_c.rdst} = 2'b00;
            endcase
         end
         6'b100011: {d_c.rw, d_c.as, d_c.m2r} = 3'b111;
         6'b101011: {d_c.mw, d_c.as} = 2'b11;
         6'b000100: {d_c.br, d_c.alu} = 4'b1110;
         6'b001000: {d_c.rw, d_c.as} = 2'b11;
         6'b000010: j_d = 1'b1;
         default:   j_d = 1'b0;
      endcase
   end
   assign wr_e     = e_q.rdst ? e_q.rd : e_q.rt;
   assign pcsrc_m  = m_q.br & bus.ZeroM;
   assign lw_stall = e_q.m2r & e_q.rw & (wr_e != 5'd0) & ((wr_e == bus.RsD) | (wr_e == bus.RtD));
   assign jump_go  = j_d & ~lw_stall;
   // the taken branch is older than anything stalled behind it, so it cancels the stall
   assign bus.StallF = lw_stall & ~pcsrc_m;
   assign bus.StallD = lw_stall & ~pcsrc_m;
   assign bus.FlushD = pcsrc_m | jump_go;
   assign bus.FlushE = pcsrc_m | lw_stall;
   assign bus.PCSel  = pcsrc_m ? 2'b01 : jump_go ? 2'b10 : 2'b00;
   assign bus.ForwardAE = (m_q.rw && m_q.wr != 5'd0 && m_q.wr == e_q.rs) ? 2'b10 :
                          (w_q.rw && w_q.wr != 5'd0 && w_q.wr == e_q.rs) ? 2'b01 : 2'b00;
   assign bus.ForwardBE = (m_q.rw && m_q.wr != 5'd0 && m_q.wr == e_q.rt) ? 2'b10 :
                          (w_q.rw && w_q.wr != 5'd0 && w_q.wr == e_q.rt) ? 2'b01 : 2'b00;
   assign bus.RegDstE     = e_q.rdst;
   assign bus.ALUSrcE     = e_q.as;
   assign bus.ALUControlE = e_q.alu;
   assign bus.MemWriteM   = m_q.mw;
   assign bus.MemToRegW   = w_q.m2r;
   assign bus.RegWriteW   = w_q.rw;
   // a taken branch also squashes the instruction leaving Execute on the same edge
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= bus.FlushE ? '0 : d_c;
         m_q <= pcsrc_m ? '0 : {e_q.rw, e_q.m2r, e_q.mw, e_q.br, wr_e};
         w_q <= {m_q.rw, m_q.m2r, m_q.wr};
      end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl decode, staging and hazards
module tb_pipe_hazard_ctrl;
   typedef struct packed {
      logic       rw, m2r, mw, rdst, as;
      logic [2:0] alu;
   } exp_t;
   localparam exp_t ZERO = 8'h00;
   localparam exp_t BUB  = 8'h02;
   logic clk = 1'b0;
   logic reset;
   int checks = 0;
   int errors = 0;
   exp_t q[$];
   logic [5:0] hz;
   logic [3:0] fw;
   pipe_hazard_ctrl_if bus ();
   pipe_hazard_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   assign hz = {bus.PCSel, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE};
   assign fw = {bus.ForwardAE, bus.ForwardBE};
   function automatic exp_t dec(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'h00: case (fn)
            6'h20:   return 8'b10010_010;
            6'h22:   return 8'b10010_110;
            6'h24:   return 8'b10010_000;
            6'h25:   return 8'b10010_001;
            6'h2a:   return 8'b10010_111;
            default: return BUB;
         endcase
         6'h23:   return 8'b11001_010;
         6'h2b:   return 8'b00101_010;
         6'h04:   return 8'b00000_110;
         6'h08:   return 8'b10001_010;
         default: return BUB;
      endcase
   endfunction
   task automatic drv(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      bus.OpcodeD = op;
      bus.FunctD = fn;
      bus.RsD = rs;
      bus.RtD = rt;
      bus.RdD = rd;
   endtask
   task automatic refill();
      q.delete();
      repeat (3) q.push_back(ZERO);
   endtask
   // push what Decode should produce, clock once, then compare E/M/W against the queue
   task automatic tick(input bit bub_e, input bit kill_m);
      exp_t t, e, m, w;
      if (kill_m) begin
         t = q.pop_back();
         t.rw = 1'b0;
         t.m2r = 1'b0;
         t.mw = 1'b0;
         q.push_back(t);
      end
      q.push_back(bub_e ? ZERO : dec(bus.OpcodeD, bus.FunctD));
      @(posedge clk);
      #1;
      e = q[q.size()-1];
      m = q[q.size()-2];
      w = q[q.size()-3];
      checks++;
      if ({bus.RegDstE, bus.ALUSrcE, bus.ALUControlE} !== {e.rdst, e.as, e.alu}) begin
         errors++;
         $display("FAIL sb_e got %b want %b", {bus.RegDstE, bus.ALUSrcE, bus.ALUControlE}, {e.rdst, e.as, e.alu});
      end
      checks++;
      if (bus.MemWriteM !== m.mw) begin
         errors++;
         $display("FAIL sb_m got %b want %b", bus.MemWriteM, m.mw);
      end
      checks++;
      if ({bus.RegWriteW, bus.MemToRegW} !== {w.rw, w.m2r}) begin
         errors++;
         $display("FAIL sb_w got %b want %b", {bus.RegWriteW, bus.MemToRegW}, {w.rw, w.m2r});
      end
      if (q.size() > 3) void'(q.pop_front());
   endtask
   task automatic test_reset();
      reset = 1'b0;
      bus.ZeroM = 1'b0;
      drv(0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.MemWriteM, bus.RegWriteW, bus.MemToRegW, bus.RegDstE, bus.ALUSrcE, bus.ALUControlE} !== 8'h00) begin
         errors++;
         $display("FAIL rst_regs got %b want 0", {bus.MemWriteM, bus.RegWriteW, bus.MemToRegW, bus.RegDstE, bus.ALUSrcE, bus.ALUControlE});
      end
      @(negedge clk);
      reset = 1'b1;
      refill();
      #1;
      checks++;
      if (hz !== 6'b00_0000) begin
         errors++;
         $display("FAIL rst_hz got %b want 000000", hz);
      end
      drv(6'h00, 6'h20, 1, 2, 3);
      tick(0, 0);
      checks++;
      if ({bus.RegDstE, bus.ALUControlE} !== 4'b1010) begin
         errors++;
         $display("FAIL rst_add_e got %b want 1010", {bus.RegDstE, bus.ALUControlE});
      end
      drv(0, 0, 0, 0, 0);
      tick(0, 0);
      tick(0, 0);
      checks++;
      if (bus.RegWriteW !== 1'b1) begin
         errors++;
         $display("FAIL rst_add_w got %b want 1", bus.RegWriteW);
      end
   endtask
   task automatic test_forward();
      drv(6'h00, 6'h20, 1, 2, 3);
      tick(0, 0);
      drv(6'h00, 6'h22, 3, 1, 4);
      tick(0, 0);
      checks++;
      if (fw !== 4'b10_00) begin
         errors++;
         $display("FAIL fwd_mem got %b want 1000", fw);
      end
      drv(6'h00, 6'h24, 3, 0, 8);
      tick(0, 0);
      checks++;
      if (fw !== 4'b01_00) begin
         errors++;
         $display("FAIL fwd_wb got %b want 0100", fw);
      end
      drv(6'h00, 6'h20, 1, 2, 0);
      tick(0, 0);
      drv(6'h00, 6'h22, 0, 0, 5);
      tick(0, 0);
      checks++;
      if (fw !== 4'b00_00) begin
         errors++;
         $display("FAIL fwd_r0 got %b want 0000", fw);
      end
      drv(6'h00, 6'h20, 1, 2, 3);
      tick(0, 0);
      drv(6'h00, 6'h20, 9, 9, 3);
      tick(0, 0);
      drv(6'h00, 6'h22, 3, 3, 4);
      tick(0, 0);
      checks++;
      if (fw !== 4'b10_10) begin
         errors++;
         $display("FAIL fwd_prio got %b want 1010", fw);
      end
   endtask
   task automatic test_load_use();
      drv(6'h23, 0, 1, 5, 0);
      tick(0, 0);
      drv(6'h00, 6'h20, 2, 5, 6);
      #1;
      checks++;
      if (hz !== 6'b00_1101) begin
         errors++;
         $display("FAIL lu_stall got %b want 001101", hz);
      end
      tick(1, 0);
      checks++;
      if (hz !== 6'b00_0000) begin
         errors++;
         $display("FAIL lu_release got %b want 000000", hz);
      end
      tick(0, 0);
      checks++;
      if (fw !== 4'b00_01) begin
         errors++;
         $display("FAIL lu_fwd got %b want 0001", fw);
      end
      drv(6'h23, 0, 1, 0, 0);
      tick(0, 0);
      drv(6'h00, 6'h20, 0, 0, 7);
      #1;
      checks++;
      if (hz !== 6'b00_0000) begin
         errors++;
         $display("FAIL lu_r0 got %b want 000000", hz);
      end
      tick(0, 0);
   endtask
   task automatic test_branch();
      drv(6'h04, 0, 1, 2, 0);
      tick(0, 0);
      drv(6'h2b, 0, 1, 3, 0);
      tick(0, 0);
      bus.ZeroM = 1'b1;
      drv(0, 0, 0, 0, 0);
      #1;
      checks++;
      if (hz !== 6'b01_0011) begin
         errors++;
         $display("FAIL br_taken got %b want 010011", hz);
      end
      tick(1, 1);
      bus.ZeroM = 1'b0;
      checks++;
      if (bus.MemWriteM !== 1'b0) begin
         errors++;
         $display("FAIL br_sw_killed got %b want 0", bus.MemWriteM);
      end
      drv(6'h04, 0, 1, 2, 0);
      tick(0, 0);
      drv(6'h2b, 0, 1, 3, 0);
      tick(0, 0);
      drv(0, 0, 0, 0, 0);
      #1;
      checks++;
      if (hz !== 6'b00_0000) begin
         errors++;
         $display("FAIL br_not_taken got %b want 000000", hz);
      end
      tick(0, 0);
      checks++;
      if (bus.MemWriteM !== 1'b1) begin
         errors++;
         $display("FAIL br_sw_kept got %b want 1", bus.MemWriteM);
      end
      drv(6'h04, 0, 1, 2, 0);
      tick(0, 0);
      drv(6'h23, 0, 1, 5, 0);
      tick(0, 0);
      bus.ZeroM = 1'b1;
      drv(6'h00, 6'h20, 2, 5, 6);
      #1;
      checks++;
      if (hz !== 6'b01_0011) begin
         errors++;
         $display("FAIL br_over_stall got %b want 010011", hz);
      end
      tick(1, 1);
      bus.ZeroM = 1'b0;
      drv(0, 0, 0, 0, 0);
      #1;
      checks++;
      if (hz !== 6'b00_0000) begin
         errors++;
         $display("FAIL br_after got %b want 000000", hz);
      end
      tick(0, 0);
   endtask
   task automatic test_jump();
      drv(6'h02, 6'h11, 4, 7, 2);
      #1;
      checks++;
      if (hz !== 6'b10_0010) begin
         errors++;
         $display("FAIL jmp got %b want 100010", hz);
      end
      tick(0, 0);
      drv(0, 0, 0, 0, 0);
      #1;
      checks++;
      if (hz !== 6'b00_0000) begin
         errors++;
         $display("FAIL jmp_one got %b want 000000", hz);
      end
      tick(0, 0);
      drv(6'h04, 0, 1, 2, 0);
      tick(0, 0);
      drv(0, 0, 0, 0, 0);
      tick(0, 0);
      bus.ZeroM = 1'b1;
      drv(6'h02, 0, 0, 0, 0);
      #1;
      checks++;
      if (hz !== 6'b01_0011) begin
         errors++;
         $display("FAIL jmp_prio got %b want 010011", hz);
      end
      tick(1, 1);
      bus.ZeroM = 1'b0;
   endtask
   task automatic test_unknown_reset();
      drv(6'h3f, 6'h20, 5, 5, 5);
      #1;
      checks++;
      if (hz !== 6'b00_0000) begin
         errors++;
         $display("FAIL unk_hz got %b want 000000", hz);
      end
      tick(0, 0);
      drv(6'h00, 6'h00, 1, 2, 3);
      tick(0, 0);
      drv(6'h00, 6'h2a, 1, 2, 9);
      tick(0, 0);
      drv(6'h08, 0, 1, 10, 0);
      tick(0, 0);
      drv(6'h00, 6'h25, 1, 2, 11);
      tick(0, 0);
      drv(6'h2b, 0, 1, 3, 0);
      tick(0, 0);
      drv(0, 0, 0, 0, 0);
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.MemWriteM, bus.RegWriteW, bus.MemToRegW, bus.RegDstE, bus.ALUSrcE, bus.ALUControlE} !== 8'h00) begin
         errors++;
         $display("FAIL midrst_regs got %b want 0", {bus.MemWriteM, bus.RegWriteW, bus.MemToRegW, bus.RegDstE, bus.ALUSrcE, bus.ALUControlE});
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.MemWriteM !== 1'b0) begin
         errors++;
         $display("FAIL midrst_mw got %b want 0", bus.MemWriteM);
      end
      @(negedge clk);
      reset = 1'b1;
      refill();
      repeat (3) tick(0, 0);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_forward();
      test_load_use();
      test_branch();
      test_jump();
      test_unknown_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipelined control and hazard unit for the 5-stage datapath: decodes Opcode/Funct in Decode, carries control bits through Execute, Memory and Writeback pipeline registers, and generates the stall, flush, forwarding and next-PC select signals. It sits beside the datapath, with one stage register per pipeline boundary mirroring the datapath's. Branches resolve in Memory. Jumps resolve in Decode.

## Interface
- No parameters; register address width is fixed at 5 and ALU control width at 3.
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all pipeline control registers
- OpcodeD  in  6  instruction bits [31:26] in Decode
- FunctD  in  6  instruction bits [5:0] in Decode
- RsD, RtD, RdD  in  5 each  register fields in Decode
- ZeroM  in  1  registered ALU zero flag in Memory
- RegDstE  out  1  1 = write register is Rd, 0 = Rt
- ALUSrcE  out  1  1 = SrcB is the sign-extended immediate
- ALUControlE  out  3  ALU operation code
- MemWriteM  out  1  data-memory write enable
- MemToRegW  out  1  1 = write back memory data
- RegWriteW  out  1  register-file write enable
- PCSel  out  2  00 = PC+1, 01 = branch target (PCBranchM), 10 = jump target
- StallF, StallD  out  1 each  hold the PC register / hold the IF/ID register
- FlushD, FlushE  out  1 each  clear the IF/ID register / clear the ID/EX register (synchronous on next edge)
- ForwardAE, ForwardBE  out  2 each  00 = register file, 10 = ALUOutM, 01 = ResultW

## Operation
- Decode table:
  - R-type (000000): RegWrite=1, RegDst=1, ALUSrc=0. Funct map: 100000 add→010; 100010 sub→110; 100100 and→000; 100101 or→001; 101010 slt→111; any other funct is a bubble.
  - lw (100011): RegWrite=1, ALUSrc=1, MemToReg=1, ALU=010.
  - sw (101011): MemWrite=1, ALUSrc=1, ALU=010.
  - beq (000100): Branch=1, ALU=110.
  - addi (001000): RegWrite=1, ALUSrc=1, ALU=010.
  - j (000010): Jump=1.
  - Any other opcode is a bubble: all enables 0, ALU=010.
- Stage registers:
  - D→E carries RegWrite, MemToReg, MemWrite, Branch, ALUControl, ALUSrc, RegDst, Rs, Rt, Rd.
  - E→M carries RegWrite, MemToReg, MemWrite, Branch, WriteReg.
  - M→W carries RegWrite, MemToReg, WriteReg.
  - WriteRegE = RegDstE ? RdE : RtE.
- Branch: PCSrcM = BranchM & ZeroM. When set: PCSel=01, FlushD=1, FlushE=1, and the E→M register loads a bubble on the same edge.
- Jump: JumpD on a valid, non-stalled Decode gives PCSel=10 and FlushD=1. PCSrcM has priority over JumpD (the branch is the older instruction).
- Load-use hazard: asserted when MemToRegE & RegWriteE & WriteRegE≠0 & (WriteRegE==RsD | WriteRegE==RtD). Response: StallF=1, StallD=1, FlushE=1.
- Taken branch overrides a stall: StallF=StallD=0, so the PC loads the target and D is flushed.
- ForwardAE:
  - 10 if RegWriteM & WriteRegM≠0 & WriteRegM==RsE;
  - else 01 if RegWriteW & WriteRegW≠0 & WriteRegW==RsE;
  - else 00.
  - The Memory stage wins when both Memory and Writeback match.
- ForwardBE: same rule applied to RtE.
- Register 0 never forwards and never causes a stall.

## Timing
- Reset (reset=0, asynchronous): every stage register clears to bubble. All registered outputs are 0 while reset is low and on the first edge after release. PCSel=00.
- Stage outputs are registered (E, M, W). PCSel, Stall*, Flush* and Forward* are combinational from stage registers and D inputs, valid in the same cycle.
- Control latency: decoded bits appear at E one edge after Decode, at M after 2 edges, at W after 3 edges.
- FlushE and a load-use stall both insert the bubble into D→E on the next edge. StallD holds D→E's source (the IF/ID register), not D→E itself.
- Branch penalty: 3 cycles. Jump penalty: 1 cycle. Load-use penalty: 1 cycle.
- Reset asserted mid-operation: in-flight control is discarded immediately and no write enable may remain high.

## Test plan
- Reset: hold reset=0, then release → RegWriteW=0, MemWriteM=0, PCSel=00, no Stall/Flush asserted. Feed add (000000/100000) → ALUControlE=010 and RegDstE=1 after 1 edge, RegWriteW=1 after 3 edges.
- Forwarding: add $3 followed by sub using $3 as Rs → ForwardAE=10. A second dependent instruction issued 2 cycles later → ForwardAE=01. A dependency on $0 → 00.
- Load-use: lw $5 followed by add with Rt=$5 → StallF=StallD=FlushE=1 for exactly 1 cycle, then ForwardBE=01.
- Branch: beq with ZeroM=1 reaching Memory → PCSel=01, FlushD=FlushE=1. MemWriteM=0 for a following sw. With ZeroM=0 → no flush.
- Jump and priority: j in Decode → PCSel=10 and FlushD=1 for 1 cycle. j in Decode together with a taken beq in Memory → PCSel=01.
- Unknown opcode 111111, and reset pulsed low during an sw in Execute → all enables 0, and MemWriteM never goes high.
